// File: rtl/systolic_pkg.sv
// Shared constants and state type for the systolic MAC array, its input
// datapath and the skew feeder.
package systolic_pkg;

  localparam int DATA_W = 8;                  // operand element width
  localparam int N      = 4;                  // array dimension (lanes per edge)
  localparam int BEATS  = 2 * N - 1;          // beats per skewed lane
  localparam int SKEW_W = BEATS * DATA_W;     // skewed lane width (56)
  localparam int CNT_W  = $clog2(BEATS + N);  // wide enough for the flush tail too

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    DONE = 2'd2
  } feeder_state_e;

endpackage

// File: rtl/skew_lane.sv
// One skewed operand lane: snapshot register plus MSB-first byte shifter.
// The presented byte lives in its own register so the array edge is driven
// straight from a flop; the snapshot keeps only the bytes not yet presented.
module skew_lane
  import systolic_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic              clear,
  input  logic [SKEW_W-1:0] din,
  output logic [DATA_W-1:0] beat
);

  logic [SKEW_W-1:0] snap;

  // Snapshot/shift register; clear has priority so a finished or aborted feed
  // leaves the edge at zero.
  // NOTE: the snapshot is an ordinary register bank, not a memory, so it is
  // reset along with the rest of the state and never shows stale operands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap <= '0;
      beat <= '0;
    end else if (clear) begin
      snap <= '0;
      beat <= '0;
    end else if (load) begin
      beat <= din[SKEW_W-1 -: DATA_W];
      snap <= din << DATA_W;
    end else if (shift) begin
      // After the last real byte the snapshot is all zero, so further shifts
      // naturally produce the zero flush beats.
      beat <= snap[SKEW_W-1 -: DATA_W];
      snap <= snap << DATA_W;
    end
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skew feeder: snapshots eight skewed operand lanes on load_done and streams
// them one byte per beat onto the west (A) and north (B) array edges under a
// valid/ready handshake.
// Optional feature: define SKEW_FEEDER_FLUSH_EN to append N all-zero beats
// that drain partial products through the array before feed_done.
module systolic_skew_feeder
  import systolic_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load_done,
  input  logic [SKEW_W-1:0]   A_r1,
  input  logic [SKEW_W-1:0]   A_r2,
  input  logic [SKEW_W-1:0]   A_r3,
  input  logic [SKEW_W-1:0]   A_r4,
  input  logic [SKEW_W-1:0]   B_c1,
  input  logic [SKEW_W-1:0]   B_c2,
  input  logic [SKEW_W-1:0]   B_c3,
  input  logic [SKEW_W-1:0]   B_c4,
  input  logic                array_ready,
  output logic                feed_valid,
  output logic [N*DATA_W-1:0] a_edge,
  output logic [N*DATA_W-1:0] b_edge,
  output logic                feed_done,
  output logic                busy
);

`ifdef SKEW_FEEDER_FLUSH_EN
  localparam int TOTAL_BEATS = BEATS + N;
`else
  localparam int TOTAL_BEATS = BEATS;
`endif
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(TOTAL_BEATS - 1);

  feeder_state_e    state_q, state_d;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_d;
  logic             feed_valid_d, feed_done_d;
  logic             lane_load, lane_shift, lane_clear;

  logic [SKEW_W-1:0] a_in [N];
  logic [SKEW_W-1:0] b_in [N];

  assign a_in[0] = A_r1;
  assign a_in[1] = A_r2;
  assign a_in[2] = A_r3;
  assign a_in[3] = A_r4;
  assign b_in[0] = B_c1;
  assign b_in[1] = B_c2;
  assign b_in[2] = B_c3;
  assign b_in[3] = B_c4;

  // Next-state and control decode; load_done is only looked at in IDLE so a
  // request during a feed is dropped rather than queued.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt;
    feed_valid_d = feed_valid;
    feed_done_d  = 1'b0;
    lane_load    = 1'b0;
    lane_shift   = 1'b0;
    lane_clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_done) begin
          state_d      = FEED;
          lane_load    = 1'b1;
          feed_valid_d = 1'b1;
          beat_cnt_d   = '0;
        end
      end
      FEED: begin
        if (feed_valid && array_ready) begin
          beat_cnt_d = beat_cnt + 1'b1;
          if (beat_cnt == LAST_BEAT) begin
            state_d      = DONE;
            lane_clear   = 1'b1;
            feed_valid_d = 1'b0;
            feed_done_d  = 1'b1;
          end else begin
            lane_shift = 1'b1;
          end
        end
      end
      DONE: begin
        state_d      = IDLE;
        feed_valid_d = 1'b0;
      end
      default: begin
        state_d      = IDLE;
        feed_valid_d = 1'b0;
        lane_clear   = 1'b1;
      end
    endcase
  end

  // State, beat counter and registered status outputs.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      beat_cnt   <= '0;
      feed_valid <= 1'b0;
      feed_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt   <= beat_cnt_d;
      feed_valid <= feed_valid_d;
      feed_done  <= feed_done_d;
      busy       <= (state_d != IDLE);
    end
  end

  // N west-edge and N north-edge lanes; each lane's byte register drives its
  // slice of the edge directly.
  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_lane u_a_lane (
      .clk   (clk),
      .reset (reset),
      .load  (lane_load),
      .shift (lane_shift),
      .clear (lane_clear),
      .din   (a_in[i]),
      .beat  (a_edge[i*DATA_W +: DATA_W])
    );

    skew_lane u_b_lane (
      .clk   (clk),
      .reset (reset),
      .load  (lane_load),
      .shift (lane_shift),
      .clear (lane_clear),
      .din   (b_in[i]),
      .beat  (b_edge[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench for systolic_skew_feeder: table-driven feeds, hand
// sequences for stall, ignored load_done and mid-feed reset, then random feeds.
module tb_systolic_skew_feeder;
  import systolic_pkg::*;

`ifdef SKEW_FEEDER_FLUSH_EN
  localparam int TOTAL = BEATS + N;
`else
  localparam int TOTAL = BEATS;
`endif

  typedef logic [N-1:0][SKEW_W-1:0] lanes_t;

  typedef struct {
    lanes_t a;
    lanes_t b;
    int     stall_beat;
    int     stall_len;
    int     exp_done;
  } vec_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                load_done;
  logic [SKEW_W-1:0]   A_r1, A_r2, A_r3, A_r4;
  logic [SKEW_W-1:0]   B_c1, B_c2, B_c3, B_c4;
  logic                array_ready;
  logic                feed_valid;
  logic [N*DATA_W-1:0] a_edge;
  logic [N*DATA_W-1:0] b_edge;
  logic                feed_done;
  logic                busy;

  int checks = 0;
  int errors = 0;

  systolic_skew_feeder dut (
    .clk         (clk),
    .reset       (reset),
    .load_done   (load_done),
    .A_r1        (A_r1),
    .A_r2        (A_r2),
    .A_r3        (A_r3),
    .A_r4        (A_r4),
    .B_c1        (B_c1),
    .B_c2        (B_c2),
    .B_c3        (B_c3),
    .B_c4        (B_c4),
    .array_ready (array_ready),
    .feed_valid  (feed_valid),
    .a_edge      (a_edge),
    .b_edge      (b_edge),
    .feed_done   (feed_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: beat k of a lane is its k-th byte counted from the MSB; any
  // beat past the real data (flush tail) is zero.
  function automatic logic [N*DATA_W-1:0] exp_edge(input lanes_t l, input int k);
    logic [N*DATA_W-1:0] r;
    logic [SKEW_W-1:0]   t;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (k < BEATS) begin
        t = l[i] >> ((BEATS - 1 - k) * DATA_W);
        r[i*DATA_W +: DATA_W] = t[DATA_W-1:0];
      end
    end
    return r;
  endfunction

  task automatic apply_lanes(input lanes_t a, input lanes_t b);
    A_r1 = a[0]; A_r2 = a[1]; A_r3 = a[2]; A_r4 = a[3];
    B_c1 = b[0]; B_c2 = b[1]; B_c3 = b[2]; B_c4 = b[3];
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " feed_valid"}, 64'(feed_valid), 64'd0);
    check({tag, " feed_done"},  64'(feed_done),  64'd0);
    check({tag, " busy"},       64'(busy),       64'd0);
    check({tag, " a_edge"},     64'(a_edge),     64'd0);
    check({tag, " b_edge"},     64'(b_edge),     64'd0);
  endtask

  // One feed from load_done to feed_done. Cycle 0 is the cycle load_done is
  // high; observations are taken at each following negedge. Optionally stalls
  // at one beat, re-pulses load_done with changed A_r1 at beat 4, or asserts
  // reset mid-cycle while beat abort_at is presented.
  task automatic run_feed(input lanes_t a, input lanes_t b, input int stall_beat,
                          input int stall_len, input int exp_done,
                          input bit inject, input int abort_at);
    int  idx;
    int  stalls;
    int  valid_cycles;
    bit  done_seen;
    bit  injected;
    idx = 0; stalls = 0; valid_cycles = 0; done_seen = 0; injected = 0;
    @(negedge clk);
    apply_lanes(a, b);
    load_done   = 1'b1;
    array_ready = 1'b1;
    @(negedge clk);
    load_done = 1'b0;
    for (int cyc = 1; cyc <= 60 && !done_seen; cyc++) begin
      if (feed_done) begin
        check("done_cycle", 64'(cyc), 64'(exp_done));
        check("beats_accepted", 64'(idx), 64'(TOTAL));
        check("valid_cycles", 64'(valid_cycles), 64'(TOTAL + stall_len));
        check("valid_at_done", 64'(feed_valid), 64'd0);
        check("edges_at_done", {a_edge, b_edge}, 64'd0);
        done_seen = 1;
      end else begin
        valid_cycles++;
        check("feed_valid", 64'(feed_valid), 64'd1);
        check("busy", 64'(busy), 64'd1);
        check("a_edge", 64'(a_edge), 64'(exp_edge(a, idx)));
        check("b_edge", 64'(b_edge), 64'(exp_edge(b, idx)));
        if (abort_at >= 0 && idx == abort_at) begin
          #2 reset = 1'b0;
          #1 check_idle_outputs("abort");
          return;
        end
        if (inject && idx == 4 && !injected) begin
          A_r1      = ~a[0];
          load_done = 1'b1;
          injected  = 1;
        end else begin
          load_done = 1'b0;
        end
        if (idx == stall_beat && stalls < stall_len) begin
          array_ready = 1'b0;
          stalls++;
        end else begin
          array_ready = 1'b1;
          idx++;
        end
      end
      @(negedge clk);
    end
    if (!done_seen) begin
      check("feed_done_timeout", 64'd0, 64'd1);
    end else begin
      check("done_pulse_width", 64'(feed_done), 64'd0);
      check("busy_after_done", 64'(busy), 64'd0);
    end
  endtask

  vec_t   tbl[3];
  lanes_t ra, rb;
  int     rs, rl;

  initial begin
    reset = 1'b0; load_done = 1'b0; array_ready = 1'b0;
    apply_lanes('0, '0);

    // Reset held for three cycles
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b1;

    // Directed table
    tbl[0].a = {56'h0, 56'h0, 56'h00050607080000, 56'h01020304000000};
    tbl[0].b = {56'hA1A2A3A4A5A6A7, 56'h0, 56'h11223344556677, 56'h80000000000001};
    tbl[0].stall_beat = -1; tbl[0].stall_len = 0;
    tbl[0].exp_done = TOTAL + 1;
    tbl[1].a = tbl[0].a;
    tbl[1].b = tbl[0].b;
    tbl[1].stall_beat = 2; tbl[1].stall_len = 3;
    tbl[1].exp_done = TOTAL + 1 + 3;
    tbl[2].a = {4{56'hFFFFFFFFFFFFFF}};
    tbl[2].b = {56'h0F0E0D0C0B0A09, 56'hFF00FF00FF00FF, 56'h00FF00FF00FF00, 56'h12345678ABCDEF};
    tbl[2].stall_beat = BEATS - 1; tbl[2].stall_len = 2;
    tbl[2].exp_done = TOTAL + 1 + 2;
    for (int v = 0; v < 3; v++) begin
      run_feed(tbl[v].a, tbl[v].b, tbl[v].stall_beat, tbl[v].stall_len,
               tbl[v].exp_done, 1'b0, -1);
    end

    // load_done during a feed is ignored; the next one streams new data
    run_feed(tbl[0].a, tbl[0].b, -1, 0, TOTAL + 1, 1'b1, -1);
    run_feed(tbl[2].b, tbl[2].a, -1, 0, TOTAL + 1, 1'b0, -1);

    // Reset asserted mid-cycle at beat 3, then a clean feed from beat 0
    run_feed(tbl[2].a, tbl[2].b, -1, 0, TOTAL + 1, 1'b0, 3);
    @(negedge clk);
    check_idle_outputs("held_reset");
    reset = 1'b1;
    array_ready = 1'b1;
    run_feed(tbl[0].a, tbl[0].b, -1, 0, TOTAL + 1, 1'b0, -1);

    // Random feeds with a random stall
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        ra[i] = {$urandom(), $urandom()};
        rb[i] = {$urandom(), $urandom()};
      end
      rs = $urandom_range(TOTAL - 1, 0);
      rl = $urandom_range(3, 0);
      run_feed(ra, rb, rs, rl, TOTAL + 1 + rl, 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
